uart_cmd_ctrl: RTL
==================

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter pTimeoutCycles, default 480_000, is the maximum number of clock cycles allowed between bytes of one command frame.
REQ-002 iClk  in  1  system clock; every register of the block is clocked on its rising edge.
REQ-003 iResetn  in  1  reset; asynchronous, active-low.
REQ-004 iRxByte  in  8  head byte of the UART RX FIFO; valid whenever iRxEmpty=0 (first-word fall-through).
REQ-005 iRxEmpty  in  1  RX FIFO empty flag.
REQ-006 oRxRead  out  1  one-cycle pop strobe to the RX FIFO.
REQ-007 iUartError  in  1  UART framing/overrun error flag.
REQ-008 oTxByte  out  8  byte to enqueue in the TX FIFO.
REQ-009 oTxWrite  out  1  one-cycle TX enqueue strobe.
REQ-010 iTxBusy  in  1  TX FIFO cannot accept a byte.
REQ-011 oRegAddr  out  8  register bus address.
REQ-012 oRegWdata  out  8  register bus write data.
REQ-013 oRegWr  out  1  one-cycle register write strobe.
REQ-014 oRegRd  out  1  one-cycle register read strobe.
REQ-015 iRegRdata  in  8  register read data; valid exactly 1 cycle after oRegRd.
REQ-016 oBusy  out  1  high in every state except IDLE.
REQ-017 oErrCount  out  8  saturating count of aborted or invalid frames.

Function
REQ-018 The block SHALL implement the states IDLE, GET_ADDR, GET_DATA, EXEC, RD_WAIT, SEND and TX_GAP.
REQ-019 Protocol: write frame 0x57 'W', addr, data -> response 0x4B 'K'; read frame 0x52 'R', addr -> response is the 1-byte register value; any other opcode -> response 0x45 'E'.
REQ-020 Byte consumption: when iRxEmpty=0 in IDLE, GET_ADDR or GET_DATA, the block SHALL capture iRxByte and assert oRxRead for exactly that cycle; at most one pop per cycle.
REQ-021 IDLE: 'W' or 'R' -> GET_ADDR (opcode latched); any other byte -> SEND with 'E' and oErrCount +1.
REQ-022 GET_ADDR: the byte is latched into oRegAddr; opcode 'W' -> GET_DATA, opcode 'R' -> EXEC.
REQ-023 GET_DATA: the byte is latched into oRegWdata -> EXEC.
REQ-024 EXEC (1 cycle): 'W' pulses oRegWr and goes to SEND with 'K'; 'R' pulses oRegRd and goes to RD_WAIT.
REQ-025 RD_WAIT (1 cycle): iRegRdata is latched into oTxByte -> SEND.
REQ-026 SEND: the block SHALL hold until iTxBusy=0, then assert oTxWrite for one cycle with oTxByte stable, then go to TX_GAP.
REQ-027 TX_GAP (1 cycle): no TX strobe is issued, so iTxBusy can update; the block then returns to IDLE.
REQ-028 Command-to-response latency with the TX FIFO ready: for 'W', oTxWrite is asserted 2 cycles after the data-byte pop; for 'R', 3 cycles after the address-byte pop.
REQ-029 Inter-byte timeout: a counter clears on every pop and increments each cycle in GET_ADDR/GET_DATA while iRxEmpty=1; on reaching pTimeoutCycles the block SHALL return to IDLE, with no response and oErrCount +1.
REQ-030 UART error: iUartError=1 in GET_ADDR or GET_DATA SHALL abort the frame to IDLE, with no response, no pop that cycle, and oErrCount +1; in IDLE, the erroneous byte is popped and discarded with no count.
REQ-031 iUartError SHALL be ignored in EXEC, RD_WAIT, SEND and TX_GAP.
REQ-032 oErrCount SHALL saturate at 0xFF.
REQ-033 If an error, a timeout and a byte arrival occur in the same cycle, the priority SHALL be error > timeout > byte.
REQ-034 oRegRd and oRegWr SHALL never be asserted in the same cycle; oRxRead and oTxWrite are independent of each other.

Reset
REQ-035 While iResetn=0, the block SHALL be in IDLE; oRxRead, oTxWrite, oRegWr, oRegRd and oBusy=0; oTxByte, oRegAddr, oRegWdata and oErrCount=0x00; the timeout counter=0.
REQ-036 Reset asserted mid-frame or mid-SEND SHALL abandon the frame immediately; no strobe is asserted after reset releases until a new byte is received.

Verification
REQ-037 Write frame: RX 0x57,0x10,0xA5 -> one oRegWr with addr 0x10 / data 0xA5, then TX 0x4B, oErrCount=0.
REQ-038 Read frame: RX 0x52,0x22 with iRegRdata=0x3C one cycle after oRegRd -> TX 0x3C, exactly 3 cycles after the address pop.
REQ-039 Bad opcode: RX 0x41 -> TX 0x45, oErrCount=1, no register strobes.
REQ-040 Timeout: RX 0x57 only, then idle for pTimeoutCycles (set to 16) -> return to IDLE, no TX, oErrCount=1; a following 'R' frame completes normally.
REQ-041 Back-pressure: iTxBusy=1 for 50 cycles during SEND -> oTxWrite=0 throughout, then a single pulse once iTxBusy falls.
REQ-042 Reset mid-frame: after RX 0x57,0x10, pulse iResetn low -> all outputs at reset values, no oRegWr ever issued.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// UART command front-end: 'W' addr data -> reg write + 'K'; 'R' addr -> reg read + value; else 'E'.
// Response 2 cycles after the data pop (write) / 3 after the address pop (read); holds in SEND while iTxBusy.
module uart_cmd_ctrl #(
  parameter int unsigned pTimeoutCycles = 480_000
) (
  input  logic       iClk,
  input  logic       iResetn,
  input  logic [7:0] iRxByte,
  input  logic       iRxEmpty,
  output logic       oRxRead,
  input  logic       iUartError,
  output logic [7:0] oTxByte,
  output logic       oTxWrite,
  input  logic       iTxBusy,
  output logic [7:0] oRegAddr,
  output logic [7:0] oRegWdata,
  output logic       oRegWr,
  output logic       oRegRd,
  input  logic [7:0] iRegRdata,
  output logic       oBusy,
  output logic [7:0] oErrCount
);

  localparam int unsigned TW = $clog2(pTimeoutCycles + 1);
  localparam logic [7:0] OpWrite = 8'h57;
  localparam logic [7:0] OpRead  = 8'h52;
  localparam logic [7:0] RspOk   = 8'h4B;
  localparam logic [7:0] RspErr  = 8'h45;

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, EXEC, RD_WAIT, SEND, TX_GAP
  } state_t;

  state_t        state, stateNext;
  logic          isWrite, isWriteNext;
  logic [TW-1:0] toCnt, toCntNext;
  logic [7:0]    regAddrNext, regWdataNext, txByteNext;
  logic          errInc;
  logic          rxRead;
  logic          timeoutHit;

  assign timeoutHit = (toCnt == TW'(pTimeoutCycles));
  assign oBusy      = (state != IDLE);
  // The pop strobe is combinational on the FIFO flag, so it must be masked while reset is held.
  assign oRxRead    = rxRead & iResetn;

  always_comb begin
    stateNext    = state;
    isWriteNext  = isWrite;
    toCntNext    = toCnt;
    regAddrNext  = oRegAddr;
    regWdataNext = oRegWdata;
    txByteNext   = oTxByte;
    errInc       = 1'b0;
    rxRead       = 1'b0;
    oTxWrite     = 1'b0;
    oRegWr       = 1'b0;
    oRegRd       = 1'b0;

    case (state)
      IDLE: begin
        toCntNext = '0;
        if (!iRxEmpty) begin
          rxRead = 1'b1;
          if (iUartError) begin
            stateNext = IDLE;
          end else if (iRxByte == OpWrite || iRxByte == OpRead) begin
            isWriteNext = (iRxByte == OpWrite);
            stateNext   = GET_ADDR;
          end else begin
            txByteNext = RspErr;
            errInc     = 1'b1;
            stateNext  = SEND;
          end
        end
      end

      GET_ADDR, GET_DATA: begin
        // Priority: line error, then inter-byte timeout, then byte arrival.
        if (iUartError || timeoutHit) begin
          errInc    = 1'b1;
          toCntNext = '0;
          stateNext = IDLE;
        end else if (!iRxEmpty) begin
          rxRead    = 1'b1;
          toCntNext = '0;
          if (state == GET_ADDR) begin
            regAddrNext = iRxByte;
            stateNext   = isWrite ? GET_DATA : EXEC;
          end else begin
            regWdataNext = iRxByte;
            stateNext    = EXEC;
          end
        end else begin
          toCntNext = toCnt + TW'(1);
        end
      end

      EXEC: begin
        if (isWrite) begin
          oRegWr     = 1'b1;
          txByteNext = RspOk;
          stateNext  = SEND;
        end else begin
          oRegRd    = 1'b1;
          stateNext = RD_WAIT;
        end
      end

      RD_WAIT: begin
        txByteNext = iRegRdata;
        stateNext  = SEND;
      end

      SEND: begin
        if (!iTxBusy) begin
          oTxWrite  = 1'b1;
          stateNext = TX_GAP;
        end
      end

      TX_GAP:  stateNext = IDLE;

      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      state     <= IDLE;
      isWrite   <= 1'b0;
      toCnt     <= '0;
      oRegAddr  <= 8'h00;
      oRegWdata <= 8'h00;
      oTxByte   <= 8'h00;
      oErrCount <= 8'h00;
    end else begin
      state     <= stateNext;
      isWrite   <= isWriteNext;
      toCnt     <= toCntNext;
      oRegAddr  <= regAddrNext;
      oRegWdata <= regWdataNext;
      oTxByte   <= txByteNext;
      if (errInc && oErrCount != 8'hFF) begin
        oErrCount <= oErrCount + 8'h01;
      end
    end
  end

endmodule
